dircc_debug_scan_master: RTL and testbench

//  On-chip initiator for the Nios II virtual-JTAG debug slave. It drives the vji_* strobe set (tck/tdi/ir_in/uir/cdr/sdr/udr/rti)

---
 rtl/dircc_debug_scan_master_if.sv | 37 +++
 rtl/dircc_debug_scan_master.sv | 142 ++++++++++++++
 tb/tb_dircc_debug_scan_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dircc_debug_scan_master_if.sv
// Command/response and virtual-JTAG strobe bundle between a DiRCC node
// controller, the debug scan master and the Nios II virtual-JTAG debug slave.
interface dircc_debug_scan_master_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic [IR_WIDTH-1:0] ir_out;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_udr;
  logic                jtag_state_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo, ir_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
           tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo, ir_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
           tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/dircc_debug_scan_master.sv
// On-chip virtual-JTAG initiator: runs one UIR -> CDR -> SDR -> UDR -> RTI scan
// per command and returns the captured tdo word together with ir_out.
module dircc_debug_scan_master #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2,
  parameter int RTI_TCKS = 4
) (
  input  logic clk,
  input  logic reset,
  dircc_debug_scan_master_if.master bus
);

  localparam int DIV_W = $clog2(2 * TCK_DIV);
  localparam int CNT_W = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam int RTI_W = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] HIGH_DIV = DIV_W'(TCK_DIV);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SR_WIDTH - 1);
  localparam logic [RTI_W-1:0] LAST_RTI = RTI_W'(RTI_TCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [RTI_W-1:0]    rti_q, rti_d;
  logic                tck_q, tck_d;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] ir_cap_q;
  logic [SR_WIDTH-1:0] rsp_data_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic [SR_WIDTH-1:0] shreg_q;

  logic accept;
  logic period_end;
  logic active_d;

  assign accept     = (state_q == S_IDLE) && bus.cmd_valid;
  assign period_end = (div_q == LAST_DIV);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    rti_d   = rti_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (bus.cmd_valid) state_d = S_UIR;
      end
      S_RSP: begin
        div_d = '0;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: begin
        // Every scan state advances only at the edge that closes a tck period,
        // which is also the edge that samples tdo / ir_out.
        div_d = period_end ? '0 : div_q + 1'b1;
        if (period_end) begin
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: begin
              state_d = S_SDR;
              bit_d   = '0;
            end
            S_SDR: begin
              if (bit_q == LAST_BIT) state_d = S_UDR;
              else                   bit_d   = bit_q + 1'b1;
            end
            S_UDR: begin
              state_d = S_RTI;
              rti_d   = '0;
            end
            S_RTI: begin
              if (rti_q == LAST_RTI) state_d = S_RSP;
              else                   rti_d   = rti_q + 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    active_d = (state_d != S_IDLE) && (state_d != S_RSP);
    tck_d    = active_d && (div_d >= HIGH_DIV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      rti_q      <= '0;
      tck_q      <= 1'b0;
      ir_in_q    <= '0;
      ir_cap_q   <= '0;
      rsp_data_q <= '0;
      rsp_ir_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      rti_q   <= rti_d;
      tck_q   <= tck_d;
      if (accept) ir_in_q <= bus.cmd_ir;
      if ((state_q == S_CDR) && period_end) ir_cap_q <= bus.ir_out;
      // Response registers are loaded only on entry to RSP, so a reset mid-scan
      // can never leave a partial word visible.
      if ((state_q == S_RTI) && (state_d == S_RSP)) begin
        rsp_data_q <= shreg_q;
        rsp_ir_q   <= ir_cap_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)                                shreg_q <= bus.cmd_data;
    else if ((state_q == S_SDR) && period_end) shreg_q <= {bus.tdo, shreg_q[SR_WIDTH-1:1]};
  end

  assign bus.cmd_ready      = (state_q == S_IDLE);
  assign bus.rsp_valid      = (state_q == S_RSP);
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_ir_out     = rsp_ir_q;
  assign bus.tck            = tck_q;
  assign bus.tdi            = (state_q == S_SDR) && shreg_q[0];
  assign bus.ir_in          = ir_in_q;
  assign bus.vs_uir         = (state_q == S_UIR);
  assign bus.vs_cdr         = (state_q == S_CDR);
  assign bus.vs_sdr         = (state_q == S_SDR);
  assign bus.vs_udr         = (state_q == S_UDR);
  assign bus.jtag_state_rti = (state_q == S_RTI);

endmodule

// File: tb/tb_dircc_debug_scan_master.sv
// Directed bench for dircc_debug_scan_master: default and TCK_DIV=1/RTI_TCKS=1 builds.
module tb_dircc_debug_scan_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic tdo_one = 1'b0;

  int n_uir, n_cdr, n_sdr, n_udr, n_rti, per_bad, excl_bad, tdi_seen, lat;

  dircc_debug_scan_master_if #(.SR_WIDTH(38), .IR_WIDTH(2)) bus ();
  dircc_debug_scan_master_if #(.SR_WIDTH(38), .IR_WIDTH(2)) bus2 ();

  assign bus.tdo  = tdo_one ? 1'b1 : bus.tdi;
  assign bus2.tdo = bus2.tdi;

  dircc_debug_scan_master u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dircc_debug_scan_master #(.TCK_DIV(1), .RTI_TCKS(1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic issue(input logic [1:0] ir, input logic [37:0] data);
    bus.cmd_ir    = ir;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int cyc = 0;
    int last_rise = -1;
    logic prev = 1'b0;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    per_bad = 0; excl_bad = 0; tdi_seen = 0; lat = -1;
    while (cyc < 2000) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = cyc;
        break;
      end
      if (int'(bus.vs_uir) + int'(bus.vs_cdr) + int'(bus.vs_sdr) + int'(bus.vs_udr)
          + int'(bus.jtag_state_rti) > 1) excl_bad++;
      if (bus.tdi) tdi_seen++;
      if (bus.tck && !prev) begin
        if (bus.vs_uir) n_uir++;
        if (bus.vs_cdr) n_cdr++;
        if (bus.vs_sdr) n_sdr++;
        if (bus.vs_udr) n_udr++;
        if (bus.jtag_state_rti) n_rti++;
        if (last_rise >= 0 && (cyc - last_rise) != 4) per_bad++;
        last_rise = cyc;
      end
      prev = bus.tck;
      cyc++;
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL rsp_timeout got no rsp_valid exp rsp_valid within 2000 clk");
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ack got rsp_valid,cmd_ready=%b exp 01", {bus.rsp_valid, bus.cmd_ready});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.tck, bus.tdi, bus.ir_in, bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr,
         bus.jtag_state_rti, bus.rsp_valid, bus.rsp_ir_out} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {bus.tck, bus.tdi, bus.ir_in, bus.vs_uir,
               bus.vs_cdr, bus.vs_sdr, bus.vs_udr, bus.jtag_state_rti, bus.rsp_valid, bus.rsp_ir_out});
    end
    checks++;
    if (bus.rsp_data !== 38'h0) begin
      errors++;
      $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready);
    end
  endtask

  task automatic test_loopback();
    tdo_one = 1'b0;
    bus.ir_out = 2'b01;
    issue(2'b01, 38'h2A_5A5A_A5A5);
    wait_rsp();
    checks++;
    if (lat != 180) begin
      errors++;
      $display("FAIL loop_latency got %0d exp 180", lat);
    end
    checks++;
    if (bus.rsp_data !== 38'h2A_5A5A_A5A5) begin
      errors++;
      $display("FAIL loop_data got %h exp 2a5a5aa5a5", bus.rsp_data);
    end
    checks++;
    if ({bus.ir_in, bus.rsp_ir_out} !== 4'b0101) begin
      errors++;
      $display("FAIL loop_ir got ir_in,rsp_ir_out=%b exp 0101", {bus.ir_in, bus.rsp_ir_out});
    end
    checks++;
    if (n_uir != 1 || n_cdr != 1 || n_sdr != 38 || n_udr != 1 || n_rti != 4) begin
      errors++;
      $display("FAIL strobe_counts got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d exp 1 1 38 1 4",
               n_uir, n_cdr, n_sdr, n_udr, n_rti);
    end
    checks++;
    if (per_bad != 0) begin
      errors++;
      $display("FAIL tck_period got %0d bad periods exp 0", per_bad);
    end
    checks++;
    if (excl_bad != 0) begin
      errors++;
      $display("FAIL strobe_exclusive got %0d overlaps exp 0", excl_bad);
    end
    ack();
  endtask

  task automatic test_tdo_ones();
    tdo_one = 1'b1;
    bus.ir_out = 2'b10;
    issue(2'b11, 38'h0);
    wait_rsp();
    checks++;
    if (bus.rsp_data !== 38'h3F_FFFF_FFFF) begin
      errors++;
      $display("FAIL ones_data got %h exp 3fffffffff", bus.rsp_data);
    end
    checks++;
    if (bus.rsp_ir_out !== 2'b10) begin
      errors++;
      $display("FAIL ones_ir_out got %b exp 10", bus.rsp_ir_out);
    end
    checks++;
    if (tdi_seen != 0) begin
      errors++;
      $display("FAIL ones_tdi got %0d high cycles exp 0", tdi_seen);
    end
    checks++;
    if (lat != 180) begin
      errors++;
      $display("FAIL ones_latency got %0d exp 180", lat);
    end
    ack();
    tdo_one = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    bus.ir_out = 2'b11;
    issue(2'b10, 38'h15_0F0F_3C3C);
    wait_rsp();
    bus.cmd_ir    = 2'b01;
    bus.cmd_data  = 38'h01_2345_6789;
    bus.cmd_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 38'h15_0F0F_3C3C || bus.cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_rsp got %0d unstable cycles exp 0", bad);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.vs_uir} !== 3'b010) begin
      errors++;
      $display("FAIL rsp_exit got rsp_valid,cmd_ready,vs_uir=%b exp 010",
               {bus.rsp_valid, bus.cmd_ready, bus.vs_uir});
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.vs_uir, bus.ir_in} !== 4'b0101) begin
      errors++;
      $display("FAIL second_start got cmd_ready,vs_uir,ir_in=%b exp 0101",
               {bus.cmd_ready, bus.vs_uir, bus.ir_in});
    end
    wait_rsp();
    checks++;
    if (lat != 180 || bus.rsp_data !== 38'h01_2345_6789 || bus.rsp_ir_out !== 2'b11) begin
      errors++;
      $display("FAIL second_scan got lat=%0d data=%h ir=%b exp 180 0123456789 11",
               lat, bus.rsp_data, bus.rsp_ir_out);
    end
    ack();
  endtask

  task automatic test_reset_mid_scan();
    issue(2'b10, 38'h3F_0000_FFFF);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if ({bus.vs_sdr, bus.tck} !== 2'b11) begin
      errors++;
      $display("FAIL mid_sdr got vs_sdr,tck=%b exp 11", {bus.vs_sdr, bus.tck});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.tck, bus.vs_sdr, bus.rsp_valid, bus.tdi, bus.ir_in} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset got tck,sdr,rsp_valid,tdi,ir_in=%b exp 0",
               {bus.tck, bus.vs_sdr, bus.rsp_valid, bus.tdi, bus.ir_in});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.tck, bus.rsp_valid} !== 3'b100 || bus.rsp_data !== 38'h0) begin
      errors++;
      $display("FAIL after_reset got cmd_ready,tck,rsp_valid=%b data=%h exp 100 0",
               {bus.cmd_ready, bus.tck, bus.rsp_valid}, bus.rsp_data);
    end
    issue(2'b01, 38'h2A_AAAA_5555);
    wait_rsp();
    checks++;
    if (lat != 180 || bus.rsp_data !== 38'h2A_AAAA_5555) begin
      errors++;
      $display("FAIL fresh_scan got lat=%0d data=%h exp 180 2aaaaa5555", lat, bus.rsp_data);
    end
    ack();
  endtask

  task automatic test_small_cfg();
    int cyc = 0;
    int l2 = -1;
    bus2.cmd_ir    = 2'b01;
    bus2.cmd_data  = 38'h00_0000_0001;
    bus2.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    while (cyc < 500) begin
      @(negedge clk);
      if (bus2.rsp_valid) begin
        l2 = cyc;
        break;
      end
      cyc++;
    end
    checks++;
    if (l2 != 84) begin
      errors++;
      $display("FAIL small_latency got %0d exp 84", l2);
    end
    checks++;
    if (bus2.rsp_data !== 38'h00_0000_0001) begin
      errors++;
      $display("FAIL small_data got %h exp 0000000001", bus2.rsp_data);
    end
    bus2.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus2.rsp_ready = 1'b0;
    checks++;
    if ({bus2.rsp_valid, bus2.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL small_ack got rsp_valid,cmd_ready=%b exp 01", {bus2.rsp_valid, bus2.cmd_ready});
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_ir     = 2'b00;
    bus.cmd_data   = 38'h0;
    bus.rsp_ready  = 1'b0;
    bus.ir_out     = 2'b00;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_ir    = 2'b00;
    bus2.cmd_data  = 38'h0;
    bus2.rsp_ready = 1'b0;
    bus2.ir_out    = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_tdo_ones();
    test_back_to_back();
    test_reset_mid_scan();
    test_small_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
